// File: rtl/pl_eth_pkg.sv
// pl_eth_pkg: constants and state encoding shared by the PL Ethernet TX framer
// and the RX FCS checker.
//   CRC32_*           : IEEE 802.3 CRC-32, reflected form
//   ETH_*             : minimum frame length, preamble/SFD bytes
//   framer_state_e    : TX framer states
// Macro PL_ETH_PREAMBLE_EN adds the S_PRE state (preamble + SFD generation).
package pl_eth_pkg;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT    = 32'hFFFFFFFF;

  localparam int          ETH_MIN_LEN       = 60;
  localparam logic [7:0]  ETH_PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  ETH_SFD_BYTE      = 8'hD5;
  localparam int          ETH_PREAMBLE_LEN  = 7;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
`ifdef PL_ETH_PREAMBLE_EN
    S_PRE  = 3'd1,
`endif
    S_DATA = 3'd2,
    S_PAD  = 3'd3,
    S_FCS  = 3'd4,
    S_IFG  = 3'd5
  } framer_state_e;

endpackage

// File: rtl/pl_crc32_d8.sv
// pl_crc32_d8: combinational one-byte CRC-32 step (reflected poly, LSB first).
//   crc_i  [31:0] in  : running CRC register
//   data_i [7:0]  in  : byte to absorb
//   crc_o  [31:0] out : CRC register after absorbing data_i
module pl_crc32_d8
  import pl_eth_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] c;

  always_comb begin
    c = crc_i ^ {24'h0, data_i};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    crc_o = c;
  end

endmodule

// File: rtl/pl_eth_tx_framer.sv
// pl_eth_tx_framer: Ethernet TX framing stage. Pads short frames with zeros to
// MIN_LEN bytes, appends the CRC-32 FCS (LSB byte first), then holds off for
// IFG_CYCLES idle cycles. Counts completed frames.
//   clk, rst (async, active-high)
//   s_axis_tdata/tvalid/tready/tlast : 8-bit frame input, no FCS
//   m_axis_tdata/tvalid/tready/tlast : 8-bit framed output, tlast on last FCS byte
//   tx_busy   : first input acceptance through end of IFG
//   frame_cnt : frames whose final FCS byte was handshaken (wraps)
// Macro PL_ETH_PREAMBLE_EN: emit 7x 8'h55 + 8'hD5 before each frame (not part
// of CRC, byte count or MIN_LEN).
//
// state  | meaning
// S_IDLE | waiting for s_axis_tvalid, nothing consumed
// S_PRE  | preamble/SFD emission (PL_ETH_PREAMBLE_EN only)
// S_DATA | forwarding input bytes
// S_PAD  | emitting zero pad up to MIN_LEN
// S_FCS  | emitting 4 FCS bytes, then waiting for the last one's handshake
// S_IFG  | inter-frame gap down-count
module pl_eth_tx_framer
  import pl_eth_pkg::*;
#(
  parameter int MIN_LEN    = ETH_MIN_LEN,
  parameter int IFG_CYCLES = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        tx_busy,
  output logic [31:0] frame_cnt
);

  localparam int CW = (MIN_LEN > 0) ? $clog2(MIN_LEN + 1) : 1;
  localparam int IW = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;
  localparam logic [CW-1:0] MIN_LEN_C = CW'(MIN_LEN);
  localparam logic [CW-1:0] PAD_LAST  = CW'((MIN_LEN > 0) ? MIN_LEN - 1 : 0);
  localparam logic [IW-1:0] IFG_LOAD  = IW'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

  framer_state_e state_q, state_d;
  logic [7:0]    m_tdata_q, m_tdata_d;
  logic          m_tvalid_q, m_tvalid_d;
  logic          m_tlast_q, m_tlast_d;
  logic [31:0]   crc_q, crc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    fcs_idx_q, fcs_idx_d;   // 0..3 next FCS byte, 4 = all loaded
  logic [IW-1:0] ifg_q, ifg_d;
  logic          busy_q, busy_d;
  logic [31:0]   frame_cnt_q, frame_cnt_d;
`ifdef PL_ETH_PREAMBLE_EN
  logic [2:0]    pre_idx_q, pre_idx_d;
`endif

  logic        out_free;
  logic        s_fire;
  logic [7:0]  crc_data;
  logic [31:0] crc_next;
  logic [31:0] fcs_w;
  logic [7:0]  fcs_byte;

  // Output register can take a new byte when empty or being drained this cycle.
  assign out_free      = !m_tvalid_q || m_axis_tready;
  assign s_axis_tready = (state_q == S_DATA) && out_free;
  assign s_fire        = s_axis_tready && s_axis_tvalid;
  assign crc_data      = (state_q == S_DATA) ? s_axis_tdata : 8'h00;
  assign fcs_w         = crc_q ^ CRC32_XOROUT;

  always_comb begin
    case (fcs_idx_q[1:0])
      2'd0:    fcs_byte = fcs_w[7:0];
      2'd1:    fcs_byte = fcs_w[15:8];
      2'd2:    fcs_byte = fcs_w[23:16];
      default: fcs_byte = fcs_w[31:24];
    endcase
  end

  pl_crc32_d8 u_crc (
    .crc_i  (crc_q),
    .data_i (crc_data),
    .crc_o  (crc_next)
  );

  always_comb begin
    state_d     = state_q;
    m_tdata_d   = m_tdata_q;
    m_tvalid_d  = m_tvalid_q;
    m_tlast_d   = m_tlast_q;
    crc_d       = crc_q;
    cnt_d       = cnt_q;
    fcs_idx_d   = fcs_idx_q;
    ifg_d       = ifg_q;
    busy_d      = busy_q;
    frame_cnt_d = frame_cnt_q;
`ifdef PL_ETH_PREAMBLE_EN
    pre_idx_d   = pre_idx_q;
`endif

    // Drained (or already empty) output register goes idle unless reloaded below.
    if (out_free) begin
      m_tvalid_d = 1'b0;
      m_tlast_d  = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (s_axis_tvalid) begin
`ifdef PL_ETH_PREAMBLE_EN
          state_d   = S_PRE;
          pre_idx_d = 3'd0;
`else
          state_d   = S_DATA;
`endif
        end
      end
`ifdef PL_ETH_PREAMBLE_EN
      S_PRE: begin
        if (out_free) begin
          m_tvalid_d = 1'b1;
          if (pre_idx_q == 3'(ETH_PREAMBLE_LEN)) begin
            m_tdata_d = ETH_SFD_BYTE;
            state_d   = S_DATA;
          end else begin
            m_tdata_d = ETH_PREAMBLE_BYTE;
            pre_idx_d = pre_idx_q + 3'd1;
          end
        end
      end
`endif
      S_DATA: begin
        if (s_fire) begin
          m_tdata_d  = s_axis_tdata;
          m_tvalid_d = 1'b1;
          crc_d      = crc_next;
          busy_d     = 1'b1;
          if (cnt_q != MIN_LEN_C) cnt_d = cnt_q + 1'b1;
          if (s_axis_tlast) begin
            fcs_idx_d = 3'd0;
            if ((CW+1)'(cnt_q) + (CW+1)'(1) < (CW+1)'(MIN_LEN)) state_d = S_PAD;
            else                                                  state_d = S_FCS;
          end
        end
      end
      S_PAD: begin
        if (out_free) begin
          m_tdata_d  = 8'h00;
          m_tvalid_d = 1'b1;
          crc_d      = crc_next;
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == PAD_LAST) state_d = S_FCS;
        end
      end
      S_FCS: begin
        if (fcs_idx_q != 3'd4) begin
          if (out_free) begin
            m_tdata_d  = fcs_byte;
            m_tvalid_d = 1'b1;
            m_tlast_d  = (fcs_idx_q == 3'd3);
            fcs_idx_d  = fcs_idx_q + 3'd1;
          end
        end else if (m_tvalid_q && m_tlast_q && m_axis_tready) begin
          frame_cnt_d = frame_cnt_q + 32'd1;
          crc_d       = CRC32_INIT;
          cnt_d       = '0;
          if (IFG_CYCLES == 0) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = S_IFG;
            ifg_d   = IFG_LOAD;
          end
        end
      end
      S_IFG: begin
        if (ifg_q == '0) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          ifg_d = ifg_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      m_tdata_q   <= 8'h00;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
      crc_q       <= CRC32_INIT;
      cnt_q       <= '0;
      fcs_idx_q   <= 3'd0;
      ifg_q       <= '0;
      busy_q      <= 1'b0;
      frame_cnt_q <= 32'd0;
`ifdef PL_ETH_PREAMBLE_EN
      pre_idx_q   <= 3'd0;
`endif
    end else begin
      state_q     <= state_d;
      m_tdata_q   <= m_tdata_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tlast_q   <= m_tlast_d;
      crc_q       <= crc_d;
      cnt_q       <= cnt_d;
      fcs_idx_q   <= fcs_idx_d;
      ifg_q       <= ifg_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
`ifdef PL_ETH_PREAMBLE_EN
      pre_idx_q   <= pre_idx_d;
`endif
    end
  end

  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign tx_busy       = busy_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_pl_eth_tx_framer.sv
module tb_pl_eth_tx_framer;

  localparam int MINL = 60;
  localparam int IFG  = 12;
`ifdef PL_ETH_PREAMBLE_EN
  localparam int PRE_N = 8;
`else
  localparam int PRE_N = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_tdata;
  logic        s_tvalid, s_tready, s_tlast;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tready, m_tlast;
  logic        tx_busy;
  logic [31:0] frame_cnt;

  logic [7:0]  s0_tdata;
  logic        s0_tvalid, s0_tready, s0_tlast;
  logic [7:0]  m0_tdata;
  logic        m0_tvalid, m0_tlast;
  logic        m0_tready;
  logic        tx0_busy;
  logic [31:0] frame0_cnt;

  always #5 clk = ~clk;

  pl_eth_tx_framer #(.MIN_LEN(MINL), .IFG_CYCLES(IFG)) u_dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .tx_busy(tx_busy), .frame_cnt(frame_cnt)
  );

  pl_eth_tx_framer #(.MIN_LEN(0), .IFG_CYCLES(IFG)) u_dut0 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s0_tdata), .s_axis_tvalid(s0_tvalid), .s_axis_tready(s0_tready), .s_axis_tlast(s0_tlast),
    .m_axis_tdata(m0_tdata), .m_axis_tvalid(m0_tvalid), .m_axis_tready(m0_tready), .m_axis_tlast(m0_tlast),
    .tx_busy(tx0_busy), .frame_cnt(frame0_cnt)
  );

  int total = 0;
  int bad   = 0;
  int frames_sent = 0;
  int stall_pct = 0;

  logic [8:0] exp_q[$];   // {tlast, data}
  logic [8:0] cap0[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference CRC-32 (IEEE 802.3, reflected), returns final value after XOR-out.
  function automatic logic [31:0] crc32(input logic [7:0] d[$]);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (d[k]) begin
      c ^= {24'h0, d[k]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Expected on-wire byte stream of one frame.
  task automatic push_expected(input logic [7:0] f[$], input int min_len);
    logic [7:0]  body[$];
    logic [31:0] fcs;
    body = f;
    while (body.size() < min_len) body.push_back(8'h00);
    fcs = crc32(body);
    for (int k = 0; k < PRE_N; k++) exp_q.push_back({1'b0, (k == PRE_N-1) ? 8'hD5 : 8'h55});
    foreach (body[k]) exp_q.push_back({1'b0, body[k]});
    for (int k = 0; k < 4; k++) exp_q.push_back({k == 3, fcs[8*k +: 8]});
    frames_sent++;
  endtask

  task automatic drive_frame(input logic [7:0] f[$], input int gap_pct);
    int i = 0;
    int guard = 0;
    logic fire;
    while (i < f.size()) begin
      if ($urandom_range(99) < gap_pct) begin
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
      end else begin
        s_tvalid = 1'b1;
        s_tdata  = f[i];
        s_tlast  = (i == f.size() - 1);
      end
      @(negedge clk);
      fire = s_tvalid && s_tready;
      @(posedge clk);
      #1;
      if (fire) i++;
      guard++;
      if (guard > 20000) begin
        $display("FAIL drive_timeout: got %0d bytes expected %0d", i, f.size());
        $fatal(1, "input stalled");
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || tx_busy) && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_timeout", n < 20000, 1);
    check("frame_cnt", frame_cnt, frames_sent);
  endtask

  task automatic rand_frame(output logic [7:0] f[$], input int len);
    f.delete();
    for (int k = 0; k < len; k++) f.push_back(8'($urandom));
  endtask

  // Downstream ready pattern.
  always @(posedge clk) begin
    #1;
    m_tready = (stall_pct == 0) ? 1'b1 : ($urandom_range(99) >= stall_pct);
  end

  // Compare process: output stream vs model, hold stability, IFG length.
  int         mon_pos = 0;
  bit         hold_v  = 0;
  logic [8:0] hold_val;
  bit         meas = 0;
  int         ifg_n = 0;

  always @(negedge clk) begin
    logic [8:0] e;
    if (rst) begin
      mon_pos = 0;
      meas    = 0;
      hold_v  = 0;
    end else begin
      if (hold_v) begin
        check("hold_valid", m_tvalid, 1);
        check("hold_data", {m_tlast, m_tdata}, hold_val);
      end
      hold_v   = m_tvalid && !m_tready;
      hold_val = {m_tlast, m_tdata};
      if (meas) begin
        if (tx_busy) begin
          ifg_n++;
          check("ifg_tready", s_tready, 0);
          check("ifg_tvalid", m_tvalid, 0);
          if (ifg_n > 100) begin
            check("ifg_end", ifg_n, IFG);
            meas = 0;
          end
        end else begin
          check("ifg_len", ifg_n, IFG);
          meas = 0;
        end
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte: got %0h expected none", {m_tlast, m_tdata});
        end else begin
          e = exp_q.pop_front();
          check("byte", {m_tlast, m_tdata}, e);
          mon_pos++;
          if (e[8]) begin
            mon_pos = 0;
            meas    = 1;
            ifg_n   = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && m0_tvalid) cap0.push_back({m0_tlast, m0_tdata});
  end

  initial begin
    logic [7:0] f[$];
    logic [7:0] f2[$];
    logic [7:0] ascii[$];
    int n;
    int lens[6] = '{59, 60, 61, 2, 120, 33};

    rst = 1'b1;
    s_tdata = 8'h00; s_tvalid = 1'b0; s_tlast = 1'b0;
    s0_tdata = 8'h00; s0_tvalid = 1'b0; s0_tlast = 1'b0;
    m_tready = 1'b1; m0_tready = 1'b1;
    #1;
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    ascii = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    check("model_crc_check", crc32(ascii), 32'hCBF43926);

    // 44-byte frame 0x00..0x2B: padded to 60, 64 bytes on the wire
    f.delete();
    for (int k = 0; k < 44; k++) f.push_back(8'(k));
    push_expected(f, MINL);
    check("len44_exp", exp_q.size(), 64 + PRE_N);
    drive_frame(f, 0);
    wait_idle();

    // MIN_LEN=0 instance, "123456789"
    foreach (ascii[k]) begin
      s0_tvalid = 1'b1;
      s0_tdata  = ascii[k];
      s0_tlast  = (k == 8);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!s0_tready && n < 100);
      @(posedge clk);
      #1;
    end
    s0_tvalid = 1'b0;
    s0_tlast  = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("m0_len", cap0.size(), 13 + PRE_N);
    if (cap0.size() == 13 + PRE_N) begin
      check("m0_first", cap0[PRE_N], 9'h031);
      check("m0_fcs0", cap0[PRE_N+9], 9'h026);
      check("m0_fcs1", cap0[PRE_N+10], 9'h039);
      check("m0_fcs2", cap0[PRE_N+11], 9'h0F4);
      check("m0_fcs3", cap0[PRE_N+12], 9'h1CB);
    end
    check("m0_frame_cnt", frame0_cnt, 1);

    // 100-byte frame under 50% downstream stall
    rand_frame(f, 100);
    stall_pct = 50;
    push_expected(f, MINL);
    check("len100_exp", exp_q.size(), 104 + PRE_N);
    drive_frame(f, 0);
    wait_idle();
    stall_pct = 0;

    // 1-byte frame
    f = '{8'hAB};
    push_expected(f, MINL);
    check("len1_exp", exp_q.size(), 64 + PRE_N);
    drive_frame(f, 0);
    wait_idle();

    // Two back-to-back 64-byte frames (IFG checked by the compare process)
    rand_frame(f, 64);
    rand_frame(f2, 64);
    push_expected(f, MINL);
    drive_frame(f, 0);
    push_expected(f2, MINL);
    drive_frame(f2, 0);
    wait_idle();

    // Random lengths around the pad boundary with input gaps and stalls
    foreach (lens[k]) begin
      rand_frame(f, lens[k]);
      stall_pct = 30;
      push_expected(f, MINL);
      drive_frame(f, 20);
      wait_idle();
    end
    stall_pct = 0;

    // Reset while the 2nd FCS byte is on the output
    rand_frame(f, 60);
    push_expected(f, MINL);
    drive_frame(f, 0);
    n = 0;
    while (mon_pos != PRE_N + 61 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("rst_point_found", n < 200, 1);
    rst = 1'b1;
    #1;
    check("abort_tvalid", m_tvalid, 0);
    check("abort_frame_cnt", frame_cnt, 0);
    exp_q.delete();
    frames_sent = 0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    check("abort_busy", tx_busy, 0);
    rand_frame(f, 60);
    push_expected(f, MINL);
    drive_frame(f, 0);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
